nanorv32_muldiv_ctrl: RTL and testbench



---
 rtl/nanorv32_muldiv_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nanorv32_muldiv_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, one bit per cycle over 32 cycles, with valid/ready
// handshakes on request and result sides and a synchronous flush.
module nanorv32_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q;
    logic [2:0]         op_q;
    logic [4:0]         cnt_q;
    logic [WIDTH-1:0]   a_mag_q;     // multiplicand magnitude
    logic [WIDTH-1:0]   b_mag_q;     // divisor magnitude
    logic               neg_q;       // final result must be negated
    logic [2*WIDTH-1:0] prod_q;      // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   rem_q;       // partial remainder
    logic [WIDTH-1:0]   quot_q;      // {remaining dividend bits, quotient bits}
    logic [WIDTH-1:0]   res_data_q;

    // Request decode: operand signedness, magnitudes and fast-path detection
    logic             a_signed_d, b_signed_d, a_neg_d, b_neg_d, neg_d;
    logic [WIDTH-1:0] a_mag_d, b_mag_d;
    logic             div_zero_d, div_ovf_d, fast_d;
    logic [WIDTH-1:0] fast_data_d;

    always_comb begin
        a_signed_d  = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                      (req_op == OP_DIV)  || (req_op == OP_REM);
        b_signed_d  = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        a_neg_d     = a_signed_d && req_a[WIDTH-1];
        b_neg_d     = b_signed_d && req_b[WIDTH-1];
        a_mag_d     = a_neg_d ? (~req_a + 1'b1) : req_a;
        b_mag_d     = b_neg_d ? (~req_b + 1'b1) : req_b;
        // Remainder follows the dividend's sign; everything else the sign XOR
        neg_d       = (req_op == OP_REM) ? a_neg_d : (a_neg_d ^ b_neg_d);
        div_zero_d  = req_op[2] && (req_b == '0);
        div_ovf_d   = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                      (req_a == MOST_NEG) && (req_b == '1);
        fast_d      = div_zero_d || div_ovf_d;
        fast_data_d = '0;
        if (div_zero_d) begin
            fast_data_d = req_op[1] ? req_a : '1;
        end else if (div_ovf_d) begin
            fast_data_d = req_op[1] ? '0 : MOST_NEG;
        end
    end

    // One iteration of shift-add multiply and restoring divide, plus final sign fix-up
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] prod_step_d, prod_fix_d;
    logic [WIDTH:0]     rem_shift_d;
    logic               no_borrow_d;
    logic [WIDTH-1:0]   rem_diff_d, rem_step_d, quot_step_d, quot_fix_d, rem_fix_d;
    logic [WIDTH-1:0]   result_d;

    always_comb begin
        mul_sum_d   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      (prod_q[0] ? {1'b0, a_mag_q} : {(WIDTH+1){1'b0}});
        prod_step_d = {mul_sum_d, prod_q[WIDTH-1:1]};

        rem_shift_d = {rem_q, quot_q[WIDTH-1]};
        no_borrow_d = (rem_shift_d >= {1'b0, b_mag_q});
        // When no borrow the difference is below the divisor, so it fits WIDTH bits
        rem_diff_d  = rem_shift_d[WIDTH-1:0] - b_mag_q;
        rem_step_d  = no_borrow_d ? rem_diff_d : rem_shift_d[WIDTH-1:0];
        quot_step_d = {quot_q[WIDTH-2:0], no_borrow_d};

        prod_fix_d  = neg_q ? (~prod_step_d + 1'b1) : prod_step_d;
        quot_fix_d  = neg_q ? (~quot_step_d + 1'b1) : quot_step_d;
        rem_fix_d   = neg_q ? (~rem_step_d + 1'b1)  : rem_step_d;

        if (op_q == OP_MUL) begin
            result_d = prod_fix_d[WIDTH-1:0];
        end else if (!op_q[2]) begin
            result_d = prod_fix_d[2*WIDTH-1:WIDTH];
        end else if (!op_q[1]) begin
            result_d = quot_fix_d;
        end else begin
            result_d = rem_fix_d;
        end
    end

    // Sequencer FSM: accept, iterate 32 times, hold result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            neg_q      <= 1'b0;
            prod_q     <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            res_data_q <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        cnt_q   <= '0;
                        a_mag_q <= a_mag_d;
                        b_mag_q <= b_mag_d;
                        neg_q   <= neg_d;
                        prod_q  <= {{WIDTH{1'b0}}, b_mag_d};
                        rem_q   <= '0;
                        quot_q  <= a_mag_d;
                        if (fast_d) begin
                            res_data_q <= fast_data_d;
                            state_q    <= ST_DONE;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (op_q[2]) begin
                        rem_q  <= rem_step_d;
                        quot_q <= quot_step_d;
                    end else begin
                        prod_q <= prod_step_d;
                    end
                    if (cnt_q == 5'd31) begin
                        cnt_q      <= '0;
                        res_data_q <= result_d;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CALC);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_nanorv32_muldiv_ctrl.sv
// Self-checking bench for nanorv32_muldiv_ctrl: directed RV32M cases,
// reset/flush/backpressure scenarios and randomized ops against an
// arithmetic reference model.
module tb_nanorv32_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res = 32'h0;

    always #5 clk = ~clk;

    nanorv32_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics computed with plain wide/signed arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0] ua, ub, p;
        int si, sj;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sub = {32'h0, b};
        si  = a;
        sj  = b;
        r   = 32'h0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * sub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = 32'(si / sj);
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else r = 32'(si % sj);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op, measure latency and busy time, optionally stall the result
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
        logic [31:0] exp;
        bit fast;
        int lat, bcnt;
        exp  = model(op, a, b);
        fast = op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        lat  = 1;
        bcnt = 0;
        while (!res_valid && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("res_valid op%0d", op), 32'(res_valid), 32'd1);
        check($sformatf("latency op%0d", op), 32'(lat), fast ? 32'd1 : 32'd33);
        check($sformatf("busy_cycles op%0d", op), 32'(bcnt), fast ? 32'd0 : 32'd32);
        check($sformatf("res_data op%0d a=%08h b=%08h", op, a, b), res_data, exp);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_data", res_data, exp);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("consume_valid", 32'(res_valid), 32'd0);
        check("consume_req_ready", 32'(req_ready), 32'd1);
        last_res = exp;
        $display("op=%0d a=%08h b=%08h res=%08h exp=%08h lat=%0d stall=%0d",
                 op, a, b, res_data, exp, lat, stall);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_data", res_data, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed multiply / divide cases
        do_op(3'd0, 32'd7, 32'hFFFFFFFD, 0);
        check("mul_7_neg3", res_data, 32'hFFFFFFEB);
        do_op(3'd1, 32'h80000000, 32'h80000000, 0);
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 0);
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 0);
        do_op(3'd5, 32'd100, 32'd7, 0);
        do_op(3'd7, 32'd100, 32'd7, 0);
        // Fast paths
        do_op(3'd5, 32'd5, 32'd0, 0);
        do_op(3'd6, 32'd5, 32'd0, 0);
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
        // Backpressure
        do_op(3'd4, 32'd1000, 32'hFFFFFFFD, 10);

        // Asynchronous reset in the middle of a divide
        req_valid = 1'b1; req_op = 3'd4; req_a = 32'd12345; req_b = 32'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_res_data", res_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(3'd4, 32'd12345, 32'd17, 0);

        // Flush during CALC with a competing request
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'h12345678; req_b = 32'h9ABCDEF0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("pre_flush_busy", 32'(busy), 32'd1);
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd6;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        check("flush_req_ready", 32'(req_ready), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_res_valid", 32'(res_valid), 32'd0);
        check("flush_res_data_held", res_data, last_res);
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_accept_busy", 32'(busy), 32'd0);
        check("flush_no_result", 32'(res_valid), 32'd0);
        do_op(3'd0, 32'd3, 32'd4, 0);

        // Randomized ops with corner-biased operands
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            do_op(op, a, b, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
